fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch stage for the single-cycle MIPS core, directly upstream of the control unit. Holds the PC, fetches each instruction from instruction memory over a req/ack handshake, and presents the latched instruction with its op/funct fields to the control unit and datapath. It consumes the control unit's `pc_src` and `jump` decisions to select the next PC, then retires and counts the instruction.

## Interface

- `RESET_PC`, default 32'h0000_0000: PC loaded on reset; must be word-aligned.
- `clk` input, 1 bit: single clock; all state updates on the rising edge.
- `reset_n` input, 1 bit: asynchronous, active-low reset.
- `imem_req` output, 1 bit: fetch request to instruction memory (registered).
- `imem_addr` output, 32 bits: fetch address; equals `pc`.
- `imem_ack` input, 1 bit: memory has valid data on `imem_rdata`; ignored unless `imem_req`=1.
- `imem_rdata` input, 32 bits: instruction word.
- `pc_src` input, 1 bit: take branch (from control unit).
- `jump` input, 1 bit: take jump (from control unit).
- `stall` input, 1 bit: hold the current instruction in EXEC.
- `instr` output, 32 bits: latched instruction.
- `instr_valid` output, 1 bit: `instr` is valid and executing.
- `op` output, 6 bits: `instr[31:26]`.
- `funct` output, 6 bits: `instr[5:0]`.
- `pc` output, 32 bits: address of the current instruction.
- `pc_plus4` output, 32 bits: `pc`+4, modulo 2^32.
- `retired_count` output, 32 bits: number of retired instructions.

## Operation

- FSM states are IDLE, FETCH and EXEC.
- Reset, asynchronous and taking effect immediately at any point:
  - state=IDLE, `pc`=RESET_PC, `instr`=0, `instr_valid`=0, `imem_req`=0, `retired_count`=0.
  - This applies mid-fetch and mid-EXEC.
  - Any outstanding request is abandoned; an ack arriving after reset is ignored.
- IDLE -> FETCH unconditionally on the first edge after `reset_n` rises.
- In FETCH:
  - `imem_req`=1 and `imem_addr`=`pc`; both held stable until ack.
  - If `imem_ack`=1 at the edge: `instr`<=`imem_rdata`, `instr_valid`<=1, `imem_req`<=0, state -> EXEC.
  - Otherwise remain in FETCH; wait time is unbounded.
- In EXEC:
  - `op`/`funct` drive the control unit, which returns `pc_src`/`jump` combinationally in the same cycle.
  - If `stall`=1, hold everything.
  - If `stall`=0, at the edge:
    - `pc` <= next_pc.
    - `retired_count` += 1, wrapping at 2^32.
    - `instr_valid` <= 0, `imem_req` <= 1, state -> FETCH.
- next_pc selection, in priority order:
  - `jump`=1: {`pc_plus4[31:28]`, `instr[25:0]`, 2'b00}.
  - else `pc_src`=1: `pc_plus4` + (sign-extended `instr[15:0]` << 2), 32-bit modular.
  - else `pc_plus4`.
- `jump` and `pc_src` both high: jump wins.
- `pc_src`/`jump` are ignored outside EXEC.
- `op`/`funct` are decoded from `instr` at all times; `instr` retains its last value outside EXEC.

## Timing

- Reset release edge E0 -> FETCH at E1; `imem_req`=1 and `imem_addr`=RESET_PC during the cycle after E1.
- Zero-wait memory (ack in the first request cycle) gives one instruction every 2 cycles: FETCH, EXEC.
- Each ack wait cycle adds one cycle; each `stall` cycle adds one cycle.
- `instr_valid` rises on the edge that samples the ack and falls on the retiring edge.
- `pc` changes only on a retiring edge, or asynchronously on reset.
- `pc_plus4` is combinational from `pc`.
- `pc`=32'hFFFF_FFFC gives `pc_plus4`=0 (wrap). The branch target wraps likewise.

## Test plan

- Reset then zero-wait memory returning 32'h0000_0020 (add): first req at addr 0; `op`=0, `funct`=6'h20; retire -> `pc`=4, `retired_count`=1; next req at addr 4 two cycles after the first.
- Memory ack delayed 3 cycles at `pc`=8: `imem_req`/`imem_addr`=8 stay stable for all 4 cycles; `instr_valid` rises only after the ack edge.
- Branch: `pc`=0x100, `instr[15:0]`=16'hFFFE, `pc_src`=1 -> next `pc`=0xFC. Repeat with imm=16'h0003 -> next `pc`=0x110.
- Jump with `pc_src` also high: `pc`=0x1000_0000, `instr[25:0]`=26'h0000040 -> next `pc`=0x1000_0100 (jump priority).
- Stall held 5 cycles in EXEC: `pc`, `instr` and `retired_count` unchanged and no `imem_req`; on release, retire takes exactly one edge.
- Assert `reset_n`=0 mid-FETCH, then deliver `imem_ack` during reset: outputs immediately at reset values; after release the fetch restarts at RESET_PC with `retired_count`=0.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: holds the PC, fetches over a req/ack handshake,
// presents the latched instruction and retires it using the control unit's decision.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        pc_src,
    input  logic        jump,
    input  logic        stall,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [5:0]  op,
    output logic [5:0]  funct,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [31:0] retired_count
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        EXEC
    } state_t;

    state_t      state_q;
    logic [31:0] pc_q;
    logic [31:0] instr_q;
    logic [31:0] retired_q;
    logic        req_q;
    logic        valid_q;
    logic [31:0] pc_d;
    logic [31:0] branch_off;

    assign pc_plus4      = pc_q + 32'd4;
    assign pc            = pc_q;
    assign imem_addr     = pc_q;
    assign imem_req      = req_q;
    assign instr         = instr_q;
    assign instr_valid   = valid_q;
    assign op            = instr_q[31:26];
    assign funct         = instr_q[5:0];
    assign retired_count = retired_q;

    // Jump outranks branch; both targets wrap modulo 2^32.
    always_comb begin
        branch_off = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
        pc_d       = pc_plus4;
        if (jump) begin
            pc_d = {pc_plus4[31:28], instr_q[25:0], 2'b00};
        end else if (pc_src) begin
            pc_d = pc_plus4 + branch_off;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            pc_q      <= RESET_PC;
            instr_q   <= 32'd0;
            retired_q <= 32'd0;
            req_q     <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_q <= FETCH;
                    req_q   <= 1'b1;
                end
                FETCH: begin
                    if (req_q && imem_ack) begin
                        instr_q <= imem_rdata;
                        valid_q <= 1'b1;
                        req_q   <= 1'b0;
                        state_q <= EXEC;
                    end
                end
                EXEC: begin
                    if (!stall) begin
                        pc_q      <= pc_d;
                        retired_q <= retired_q + 32'd1;
                        valid_q   <= 1'b0;
                        req_q     <= 1'b1;
                        state_q   <= FETCH;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    req_q   <= 1'b0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a chained table of fetch/retire vectors
// followed by hand-written reset sequences.
module tb_fetch_unit;

    logic        clk;
    logic        reset_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        pc_src;
    logic        jump;
    logic        stall;
    logic [31:0] instr;
    logic        instr_valid;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] retired_count;

    int testsRun;
    int testsFailed;
    int expRetired;

    typedef struct {
        logic [31:0] instr;
        logic        pcSrc;
        logic        jump;
        int          ackWait;
        int          stallCycles;
        logic [31:0] expPc;
        logic [31:0] expNext;
    } vec_t;

    vec_t vecs[12];

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .pc_src        (pc_src),
        .jump          (jump),
        .stall         (stall),
        .instr         (instr),
        .instr_valid   (instr_valid),
        .op            (op),
        .funct         (funct),
        .pc            (pc),
        .pc_plus4      (pc_plus4),
        .retired_count (retired_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic checkResetState();
        checkOutput("rstReq", imem_req, 1'b0);
        checkOutput("rstPc", pc, 32'h0);
        checkOutput("rstInstr", instr, 32'h0);
        checkOutput("rstValid", instr_valid, 1'b0);
        checkOutput("rstRetired", retired_count, 32'h0);
    endtask

    // Entered at a negedge with the DUT in FETCH at v.expPc; leaves it in
    // FETCH at v.expNext after the retiring edge.
    task automatic applyStimulus(input int idx);
        vec_t v;
        v = vecs[idx];
        checkOutput("fetchReq", imem_req, 1'b1);
        checkOutput("fetchAddr", imem_addr, v.expPc);
        checkOutput("fetchValid", instr_valid, 1'b0);
        for (int w = 0; w < v.ackWait; w++) begin
            imem_ack   = 1'b0;
            imem_rdata = 32'hBAD0_0000 + 32'(w);
            pc_src     = 1'b1;
            jump       = 1'b1;
            @(posedge clk);
            @(negedge clk);
            checkOutput("waitReq", imem_req, 1'b1);
            checkOutput("waitAddr", imem_addr, v.expPc);
            checkOutput("waitValid", instr_valid, 1'b0);
        end
        imem_ack   = 1'b1;
        imem_rdata = v.instr;
        @(posedge clk);
        @(negedge clk);
        imem_ack   = 1'b0;
        imem_rdata = 32'hFFFF_FFFF;
        pc_src     = v.pcSrc;
        jump       = v.jump;
        checkOutput("execValid", instr_valid, 1'b1);
        checkOutput("execReq", imem_req, 1'b0);
        checkOutput("execInstr", instr, v.instr);
        checkOutput("execOp", 32'(op), 32'(v.instr[31:26]));
        checkOutput("execFunct", 32'(funct), 32'(v.instr[5:0]));
        checkOutput("execPc", pc, v.expPc);
        checkOutput("execPcPlus4", pc_plus4, v.expPc + 32'd4);
        for (int s = 0; s < v.stallCycles; s++) begin
            stall = 1'b1;
            @(posedge clk);
            @(negedge clk);
            checkOutput("stallPc", pc, v.expPc);
            checkOutput("stallInstr", instr, v.instr);
            checkOutput("stallRetired", retired_count, 32'(expRetired));
            checkOutput("stallReq", imem_req, 1'b0);
            checkOutput("stallValid", instr_valid, 1'b1);
        end
        stall = 1'b0;
        @(posedge clk);
        @(negedge clk);
        pc_src = 1'b0;
        jump   = 1'b0;
        expRetired++;
        checkOutput("retirePc", pc, v.expNext);
        checkOutput("retireCount", retired_count, 32'(expRetired));
        checkOutput("retireValid", instr_valid, 1'b0);
        checkOutput("retireReq", imem_req, 1'b1);
    endtask

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        expRetired  = 0;
        // instr, pcSrc, jump, ackWait, stallCycles, expPc, expNext
        vecs[0]  = '{32'h0000_0020, 1'b0, 1'b0, 0, 0, 32'h0000_0000, 32'h0000_0004};
        vecs[1]  = '{32'h0000_0000, 1'b0, 1'b0, 0, 0, 32'h0000_0004, 32'h0000_0008};
        vecs[2]  = '{32'h1000_003D, 1'b1, 1'b0, 3, 0, 32'h0000_0008, 32'h0000_0100};
        vecs[3]  = '{32'h1000_FFFE, 1'b1, 1'b0, 0, 0, 32'h0000_0100, 32'h0000_00FC};
        vecs[4]  = '{32'h0800_0040, 1'b0, 1'b1, 0, 0, 32'h0000_00FC, 32'h0000_0100};
        vecs[5]  = '{32'h1000_0003, 1'b1, 1'b0, 0, 5, 32'h0000_0100, 32'h0000_0110};
        vecs[6]  = '{32'h1000_FFBA, 1'b1, 1'b0, 1, 0, 32'h0000_0110, 32'hFFFF_FFFC};
        vecs[7]  = '{32'h1000_0003, 1'b1, 1'b0, 0, 0, 32'hFFFF_FFFC, 32'h0000_000C};
        vecs[8]  = '{32'h0BFF_FFFF, 1'b0, 1'b1, 0, 0, 32'h0000_000C, 32'h0FFF_FFFC};
        vecs[9]  = '{32'h0000_0000, 1'b0, 1'b0, 0, 0, 32'h0FFF_FFFC, 32'h1000_0000};
        vecs[10] = '{32'h0800_0040, 1'b1, 1'b1, 0, 1, 32'h1000_0000, 32'h1000_0100};
        vecs[11] = '{32'h1000_FFFE, 1'b0, 1'b0, 2, 0, 32'h1000_0100, 32'h1000_0104};

        reset_n    = 1'b0;
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
        pc_src     = 1'b0;
        jump       = 1'b0;
        stall      = 1'b0;
        repeat (2) @(negedge clk);
        checkResetState();

        reset_n = 1'b1;
        #1;
        checkOutput("idleReq", imem_req, 1'b0);
        @(posedge clk);
        @(negedge clk);
        checkOutput("firstReq", imem_req, 1'b1);
        checkOutput("firstAddr", imem_addr, 32'h0);

        for (int i = 0; i < 12; i++) begin
            applyStimulus(i);
        end

        // Reset mid-FETCH, with an ack delivered while reset is held.
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        checkResetState();
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        @(posedge clk);
        @(negedge clk);
        checkResetState();
        imem_ack   = 1'b0;
        reset_n    = 1'b1;
        expRetired = 0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("restartReq", imem_req, 1'b1);
        checkOutput("restartAddr", imem_addr, 32'h0);
        checkOutput("restartRetired", retired_count, 32'h0);
        applyStimulus(0);

        // Reset mid-EXEC clears the executing instruction immediately.
        imem_ack   = 1'b1;
        imem_rdata = 32'h0000_0020;
        @(posedge clk);
        @(negedge clk);
        imem_ack = 1'b0;
        checkOutput("midExecValid", instr_valid, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        checkResetState();
        @(negedge clk);
        reset_n = 1'b1;

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
